// File: rtl/ctrl_lectura_pkg.sv
// ctrl_lectura_pkg
// Shared definitions for the memory read-fetch sequencer (control_lectura_mem).
// Contents:
//   state_t        FSM state encoding (3 bits)
//   WORD_BYTES     pixels (bytes) packed in one 32-bit memory word
//   IMG_W, IMG_H   default image size in pixels
//   NUM_WORDS_DEF  default number of memory words in one frame
package ctrl_lectura_pkg;

  // Fetch sequence per word: CHECK -> REQ -> WAIT_ACK -> SAVE -> HOLD
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_REQ      = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_SAVE     = 3'd4,
    ST_HOLD     = 3'd5
  } state_t;

  localparam int WORD_BYTES    = 4;
  localparam int IMG_W         = 128;
  localparam int IMG_H         = 128;
  localparam int NUM_WORDS_DEF = IMG_W * IMG_H / WORD_BYTES;

endpackage

// File: rtl/control_lectura_mem.sv
// control_lectura_mem
// Walks a contiguous block of NUM_WORDS 32-bit words starting at BASE_ADDR.
// Each word is fetched with a single-outstanding req/ack handshake, registered,
// and written into buffer_pixeles_mem with a one-cycle save_mem_data strobe,
// but only after the buffer has reported space_available.
//
// Ports:
//   clk, reset       system clock; synchronous active-high reset
//   start            one-cycle pulse, starts a frame when idle
//   mem_req/mem_addr memory read request (level) and word address
//   mem_ack          one-cycle acknowledge, mem_rdata valid in that cycle
//   mem_rdata        memory read data
//   space_available  buffer can accept one more word
//   save_mem_data    one-cycle write strobe to the buffer
//   memory_data      registered word presented to the buffer
//   busy             frame in progress
//   done             one-cycle pulse after the last word has been saved
//
// Build option:
//   CTRL_LECTURA_CONTINUO_EN  when defined, the frame restarts automatically
//                             after the last word (done still pulses, busy
//                             stays high) until reset.
module control_lectura_mem
  import ctrl_lectura_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 18,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    NUM_WORDS  = NUM_WORDS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  input  logic                  space_available,
  output logic                  save_mem_data,
  output logic [31:0]           memory_data,
  output logic                  busy,
  output logic                  done
);

  localparam int               CNT_W = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_WORDS);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] counter;
  logic             frame_end;

  // counter already holds the number of saved words when HOLD is reached
  assign frame_end = (counter == LAST);

  // The request and the write strobe are pure state decodes, so they never
  // depend combinationally on the memory or buffer inputs.
  assign mem_req       = (state == ST_REQ) || (state == ST_WAIT_ACK);
  assign save_mem_data = (state == ST_SAVE);

  // Next-state logic. HOLD deliberately ignores space_available: the buffer
  // needs that cycle to update its flag after the write we just issued.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (start) state_next = ST_CHECK;
      ST_CHECK:    if (space_available) state_next = ST_REQ;
      ST_REQ:      state_next = ST_WAIT_ACK;
      ST_WAIT_ACK: if (mem_ack) state_next = ST_SAVE;
      ST_SAVE:     state_next = ST_HOLD;
      ST_HOLD: begin
        if (frame_end) begin
`ifdef CTRL_LECTURA_CONTINUO_EN
          state_next = ST_CHECK;
`else
          state_next = ST_IDLE;
`endif
        end else begin
          state_next = ST_CHECK;
        end
      end
      default:     state_next = ST_IDLE;
    endcase
  end

  // State register plus datapath: word counter, address, captured data and
  // the busy/done flags. mem_addr is kept equal to BASE_ADDR + counter
  // (modulo 2**ADDR_WIDTH) by stepping both together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      counter     <= '0;
      mem_addr    <= BASE_ADDR;
      memory_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            counter  <= '0;
            mem_addr <= BASE_ADDR;
          end
        end
        ST_WAIT_ACK: begin
          if (mem_ack) memory_data <= mem_rdata;
        end
        ST_SAVE: begin
          counter  <= counter + CNT_W'(1);
          mem_addr <= mem_addr + ADDR_WIDTH'(1);
        end
        ST_HOLD: begin
          if (frame_end) begin
            done     <= 1'b1;
            counter  <= '0;
            mem_addr <= BASE_ADDR;
`ifndef CTRL_LECTURA_CONTINUO_EN
            busy     <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_lectura_mem.sv
// tb_control_lectura_mem
// Self-checking bench for control_lectura_mem (ADDR_WIDTH=18, BASE_ADDR=0x100).
// A memory responder acknowledges requests after a programmable delay, checks
// the requested address against its own word index and pushes the returned
// word into a scoreboard queue; a monitor pops the queue on each
// save_mem_data strobe and compares memory_data.
// With CTRL_LECTURA_CONTINUO_EN defined the DUT is built with NUM_WORDS=2 and
// the looping frame is exercised instead of the single-frame sequence.
module tb_control_lectura_mem;

  localparam int              AW   = 18;
  localparam logic [AW-1:0]   BASE = 18'h100;
`ifdef CTRL_LECTURA_CONTINUO_EN
  localparam int              NW   = 2;
`else
  localparam int              NW   = 4;
`endif

  logic          clk;
  logic          reset;
  logic          start;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic          space_available;
  logic          save_mem_data;
  logic [31:0]   memory_data;
  logic          busy;
  logic          done;

  int          tests      = 0;
  int          fails      = 0;
  int          ack_delay  = 1;
  int          word_idx   = 0;
  int          save_cnt   = 0;
  int          done_cnt   = 0;
  bit          inject_ack = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] patt [4] = '{32'haabbccdd, 32'habcdef77, 32'h12345678, 32'h87654321};

  control_lectura_mem #(
    .ADDR_WIDTH(AW),
    .BASE_ADDR (BASE),
    .NUM_WORDS (NW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .space_available(space_available),
    .save_mem_data  (save_mem_data),
    .memory_data    (memory_data),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: count it, and count and report it when it does not hold.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle; returns at the falling edge of the cycle after
  // the start was sampled (the DUT is then in CHECK).
  task automatic applyStimulus();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic newFrame(input int delay);
    word_idx  = 0;
    save_cnt  = 0;
    done_cnt  = 0;
    ack_delay = delay;
    exp_q.delete();
  endtask

  // Wait (bounded) for the done pulse, check busy alongside it and that the
  // pulse lasts a single cycle.
  task automatic waitDone(input int budget, input logic exp_busy);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_within_budget", 64'(done), 64'(1));
    checkOutput("busy_at_done", 64'(busy), 64'(exp_busy));
    @(negedge clk);
    checkOutput("done_one_cycle", 64'(done), 64'(0));
  endtask

  // Memory responder: acknowledges a request after ack_delay cycles of
  // mem_req, returning the next pattern word; random data otherwise.
  initial begin : memory_model
    int cnt;
    cnt       = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mem_ack = 1'b0;
        cnt     = 0;
      end else if (mem_ack) begin
        mem_ack   = 1'b0;
        cnt       = 0;
        mem_rdata = $urandom;
      end else if (inject_ack) begin
        inject_ack = 1'b0;
        mem_ack    = 1'b1;
        mem_rdata  = $urandom;
      end else if (mem_req) begin
        cnt++;
        if (cnt > ack_delay) begin
          checkOutput("req_addr", 64'(mem_addr), 64'(BASE + AW'(word_idx)));
          mem_ack   = 1'b1;
          mem_rdata = patt[word_idx % 4];
          exp_q.push_back(mem_rdata);
          word_idx  = (word_idx + 1) % NW;
        end
      end else begin
        cnt       = 0;
        mem_rdata = $urandom;
      end
    end
  end

  // Buffer-side monitor: every write must match the oldest acknowledged word.
  initial begin : save_monitor
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (save_mem_data) begin
          save_cnt++;
          if (exp_q.size() == 0)
            checkOutput("save_without_ack", 64'(save_cnt), 64'(0));
          else
            checkOutput("memory_data", 64'(memory_data), 64'(exp_q.pop_front()));
        end
        if (done) done_cnt++;
      end
    end
  end

  initial begin : main
    int   n;
    logic seen_req;
    logic seen_save;
    logic stable;
    logic [AW-1:0] held;

    reset           = 1'b1;
    start           = 1'b0;
    space_available = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_mem_req", 64'(mem_req), 64'(0));
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'(BASE));
    checkOutput("rst_save", 64'(save_mem_data), 64'(0));
    checkOutput("rst_memory_data", 64'(memory_data), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_done", 64'(done), 64'(0));
    reset = 1'b0;

`ifdef CTRL_LECTURA_CONTINUO_EN
    // Looping frame: addresses BASE, BASE+1, BASE, ... and done every 2 saves
    newFrame(1);
    applyStimulus();
    for (int k = 1; k <= 3; k++) begin
      waitDone(100, 1'b1);
      checkOutput("loop_saves", 64'(save_cnt), 64'(2 * k));
      checkOutput("loop_busy", 64'(busy), 64'(1));
    end
    checkOutput("loop_dones", 64'(done_cnt), 64'(3));
`else
    // Basic frame: immediate ack, buffer always has room
    newFrame(1);
    applyStimulus();
    checkOutput("busy_after_start", 64'(busy), 64'(1));
    checkOutput("req_in_check", 64'(mem_req), 64'(0));
    @(negedge clk);
    checkOutput("req_visible", 64'(mem_req), 64'(1));
    checkOutput("first_addr", 64'(mem_addr), 64'(BASE));
    @(negedge clk);
    checkOutput("no_save_in_wait", 64'(save_mem_data), 64'(0));
    @(negedge clk);
    checkOutput("first_save_latency", 64'(save_mem_data), 64'(1));
    waitDone(100, 1'b0);
    checkOutput("t1_saves", 64'(save_cnt), 64'(4));
    checkOutput("t1_dones", 64'(done_cnt), 64'(1));
    checkOutput("t1_queue_empty", 64'(exp_q.size()), 64'(0));
    checkOutput("t1_addr_back", 64'(mem_addr), 64'(BASE));

    // Buffer full for 10 cycles: no request, no write
    newFrame(1);
    space_available = 1'b0;
    applyStimulus();
    seen_req  = 1'b0;
    seen_save = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen_req  = seen_req | mem_req;
      seen_save = seen_save | save_mem_data;
    end
    checkOutput("full_no_req", 64'(seen_req), 64'(0));
    checkOutput("full_no_save", 64'(seen_save), 64'(0));
    space_available = 1'b1;
    @(negedge clk);
    checkOutput("req_after_space", 64'(mem_req), 64'(1));
    waitDone(100, 1'b0);
    checkOutput("t2_saves", 64'(save_cnt), 64'(4));

    // Slow memory: request and address must hold for the 7 waiting cycles
    newFrame(7);
    applyStimulus();
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    held   = mem_addr;
    stable = 1'b1;
    repeat (7) begin
      if (mem_req !== 1'b1 || mem_addr !== held) stable = 1'b0;
      @(negedge clk);
    end
    checkOutput("slow_req_stable", 64'(stable), 64'(1));
    checkOutput("slow_no_early_save", 64'(save_cnt), 64'(0));
    @(negedge clk);
    checkOutput("slow_save", 64'(save_mem_data), 64'(1));
    waitDone(300, 1'b0);
    checkOutput("t3_saves", 64'(save_cnt), 64'(4));

    // Spurious ack in CHECK and start while busy are both ignored
    newFrame(1);
    space_available = 1'b0;
    applyStimulus();
    inject_ack = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("spurious_ack_no_req", 64'(mem_req), 64'(0));
    space_available = 1'b1;
    repeat (6) @(negedge clk);
    applyStimulus();
    waitDone(100, 1'b0);
    checkOutput("t4_saves", 64'(save_cnt), 64'(4));
    checkOutput("t4_dones", 64'(done_cnt), 64'(1));
    repeat (2) @(negedge clk);
    checkOutput("t4_stays_idle", 64'(busy), 64'(0));

    // Reset while waiting for the ack of word 2, then a clean refetch
    newFrame(5);
    applyStimulus();
    n = 0;
    while (save_cnt < 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (mem_req !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_mem_req", 64'(mem_req), 64'(0));
    checkOutput("midrst_busy", 64'(busy), 64'(0));
    checkOutput("midrst_mem_addr", 64'(mem_addr), 64'(BASE));
    reset = 1'b0;
    newFrame(1);
    applyStimulus();
    waitDone(100, 1'b0);
    checkOutput("t5_saves", 64'(save_cnt), 64'(4));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
